// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_arb_pkg
//  Purpose  : Shared types and helpers for the multiplier-sharing arbiter.
//             Holds the arbiter state encoding, default sizing and the
//             packed-operand slice offset helper.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package mul_arb_pkg;

    localparam int c_dp_width_default = 5;
    localparam int c_n_req_default    = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Bit offset of requester idx's operand inside a packed operand bus.
    function automatic int slice_offset(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_picker
//  Purpose  : Combinational round-robin picker. Returns the first set request
//             at or after rr_ptr, searching circularly.
//  Ports    : req     in  n_req  request vector
//             rr_ptr  in  idx_w  highest-priority position
//             valid   out 1      at least one request present
//             winner  out idx_w  selected requester index
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_picker
    import mul_arb_pkg::*;
#(
    parameter int n_req = c_n_req_default,
    parameter int idx_w = $clog2(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [idx_w-1:0] rr_ptr,
    output logic             valid,
    output logic [idx_w-1:0] winner
);

    // Duplicating the vector turns the circular search into a plain shift:
    // after shifting right by rr_ptr, the low n_req bits are the requests
    // reordered so that position 0 is rr_ptr.
    logic [2*n_req-1:0] w_dbl;
    logic [n_req-1:0]   w_window;
    logic [idx_w-1:0]   w_off;
    logic [idx_w:0]     w_sum;

    assign w_dbl    = {req, req};
    assign w_window = n_req'(w_dbl >> rr_ptr);
    assign valid    = |req;

    // Lowest set bit of the rotated window; iterating downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_off = '0;
        for (int i = n_req - 1; i >= 0; i--) begin
            if (w_window[i]) begin
                w_off = idx_w'(i);
            end
        end
    end

    // Undo the rotation: (rr_ptr + offset) mod n_req, n_req need not be 2^k.
    assign w_sum  = {1'b0, rr_ptr} + {1'b0, w_off};
    assign winner = (w_sum >= (idx_w+1)'(n_req)) ? idx_w'(w_sum - (idx_w+1)'(n_req))
                                                  : w_sum[idx_w-1:0];

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_arbiter
//  Purpose  : Shares one sequential multiplier among n_req requesters with
//             round-robin arbitration, operand latching, Start pulse and
//             Ready-fall/Ready-rise completion tracking.
//  Ports    : clock            in   system clock, rising edge
//             reset_b          in   asynchronous active-low reset
//             req              in   per-requester request, held until ack
//             multiplicand_in  in   packed operands, slice i = requester i
//             multiplier_in    in   packed operands, slice i = requester i
//             ack              out  one-hot pulse, operands accepted
//             done             out  one-hot pulse, product_out valid
//             product_out      out  last result, held until next completion
//             busy             out  high from ack through done
//             mul_start        out  multiplier Start
//             mul_multiplicand out  latched operand
//             mul_multiplier   out  latched operand
//             mul_product      in   multiplier Product
//             mul_ready        in   multiplier Ready (high = idle/valid)
//  Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int dp_width = c_dp_width_default,
    parameter int n_req    = c_n_req_default
) (
    input  logic                    clock,
    input  logic                    reset_b,
    input  logic [n_req-1:0]        req,
    input  logic [n_req*dp_width-1:0] multiplicand_in,
    input  logic [n_req*dp_width-1:0] multiplier_in,
    output logic [n_req-1:0]        ack,
    output logic [n_req-1:0]        done,
    output logic [2*dp_width-1:0]   product_out,
    output logic                    busy,
    output logic                    mul_start,
    output logic [dp_width-1:0]     mul_multiplicand,
    output logic [dp_width-1:0]     mul_multiplier,
    input  logic [2*dp_width-1:0]   mul_product,
    input  logic                    mul_ready
);

    localparam int idx_w = $clog2(n_req);

    arb_state_t              r_state;
    logic [idx_w-1:0]        r_rr_ptr;
    logic [idx_w-1:0]        r_grant_idx;
    logic [n_req-1:0]        r_ack;
    logic [n_req-1:0]        r_done;
    logic                    r_busy;
    logic                    r_mul_start;
    logic [dp_width-1:0]     r_mcand;
    logic [dp_width-1:0]     r_mplier;
    logic [2*dp_width-1:0]   r_product;

    logic                    w_valid;
    logic [idx_w-1:0]        w_winner;
    logic [dp_width-1:0]     w_sel_mcand;
    logic [dp_width-1:0]     w_sel_mplier;

    rr_priority_picker #(
        .n_req (n_req),
        .idx_w (idx_w)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_valid),
        .winner (w_winner)
    );

    assign w_sel_mcand  = multiplicand_in[slice_offset(int'(w_winner), dp_width) +: dp_width];
    assign w_sel_mplier = multiplier_in[slice_offset(int'(w_winner), dp_width) +: dp_width];

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_product   <= '0;
        end else begin
            // Strobes default low; each state raises the ones it owns.
            r_ack       <= '0;
            r_done      <= '0;
            r_mul_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A multiplier still busy out of reset must not be fed.
                    if (w_valid && mul_ready) begin
                        r_mcand     <= w_sel_mcand;
                        r_mplier    <= w_sel_mplier;
                        r_grant_idx <= w_winner;
                        r_ack       <= n_req'(1) << w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= LAUNCH;
                    end else begin
                        r_busy      <= 1'b0;
                    end
                end
                LAUNCH: begin
                    r_mul_start <= 1'b1;
                    r_state     <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Ready is still high for a cycle after Start is sampled;
                    // only its fall marks the operation as really started.
                    if (!mul_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (mul_ready) begin
                        r_product <= mul_product;
                        r_done    <= n_req'(1) << r_grant_idx;
                        if (r_grant_idx == idx_w'(n_req - 1)) begin
                            r_rr_ptr <= '0;
                        end else begin
                            r_rr_ptr <= r_grant_idx + 1'b1;
                        end
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack              = r_ack;
    assign done             = r_done;
    assign busy             = r_busy;
    assign mul_start        = r_mul_start;
    assign mul_multiplicand = r_mcand;
    assign mul_multiplier   = r_mplier;
    assign product_out      = r_product;

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one sequential binary multiplier among n_req requesters.
- Multiplier interface: Start/Ready handshake, operands Multiplicand/Multiplier, result Product.
- Arbitrates round-robin, latches the winner's operands, pulses the multiplier Start, and waits for Ready to fall then rise.
- Returns the product with a one-cycle done strobe to the granted requester.
- Sits between the requester-side datapath blocks and the single multiplier instance.

Parameters:
- dp_width, 5, operand width; Product width is 2*dp_width.
- n_req, 4, number of requesters (2..8).
- idx_w, $clog2(n_req), grant index width (localparam, derived).

Ports:
- clock  input  1  system clock, rising edge.
- reset_b  input  1  asynchronous active-low reset.
- req  input  n_req  request per requester; held until ack.
- multiplicand_in  input  n_req*dp_width  packed operands; slice i belongs to requester i.
- multiplier_in  input  n_req*dp_width  packed operands; slice i belongs to requester i.
- ack  output  n_req  one-hot 1-cycle pulse: operands of requester i accepted.
- done  output  n_req  one-hot 1-cycle pulse: product_out valid for requester i.
- product_out  output  2*dp_width  last result; held until the next completion.
- busy  output  1  high from ack until done inclusive.
- mul_start  output  1  to multiplier Start.
- mul_multiplicand  output  dp_width  latched operand to multiplier.
- mul_multiplier  output  dp_width  latched operand to multiplier.
- mul_product  input  2*dp_width  from multiplier Product.
- mul_ready  input  1  from multiplier Ready; high = idle / result valid.

Behaviour:
- Reset (async, reset_b=0):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - ack, done, busy, mul_start = 0.
  - mul_multiplicand, mul_multiplier, product_out = 0.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If |req and mul_ready=1: winner = first set req at or after rr_ptr (circular).
  - Same edge: latch winner's operands into mul_multiplicand/mul_multiplier, grant_idx=winner, ack[winner]=1 for one cycle, busy=1, go LAUNCH.
  - If mul_ready=0 in IDLE (multiplier still busy after reset), no grant is issued.
- LAUNCH: mul_start=1 for exactly one cycle; go WAIT_BUSY.
- WAIT_BUSY: mul_start=0; on mul_ready=0 go WAIT_DONE. This covers the multiplier's one-cycle Start-to-busy latency.
- WAIT_DONE: on mul_ready=1:
  - product_out <= mul_product.
  - done[grant_idx]=1 for one cycle; busy stays high that cycle, drops next.
  - rr_ptr <= grant_idx+1, wrapping n_req-1 -> 0.
  - Go IDLE.
- Operand registers are stable from LAUNCH through WAIT_DONE; new req activity never disturbs them.
- Latency: ack cycle to done is dp_width+4 cycles with the standard multiplier (Start sampled, dp_width shift cycles, Ready return). Earliest back-to-back ack is the cycle after done.
- Requester rules:
  - req and operands must be stable from assertion until ack.
  - Dropping req before ack withdraws the request with no side effect.
  - req still high in the cycle after ack is treated as a new request.
- Fairness: the requester granted last has lowest priority next time. A continuously requesting set of k requesters is served in strict rotation.
- Simultaneous events:
  - done and a new req in the same cycle: the new req is considered in IDLE on the next cycle, never in the done cycle.
  - Reset dominates everything.
- Reset mid-operation: FSM returns to IDLE and no done is issued. The multiplier shares reset_b, so no stale Ready is consumed.
- Product width: 2*dp_width, unsigned, no truncation.

Decomposition:
- Package mul_arb_pkg holds:
  - state encoding (typedef enum, 2 bits);
  - default dp_width/n_req localparams;
  - a function computing the packed-slice offset i*dp_width.
- One sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: valid and winner index.
  - Implemented with double-width rotate-and-mask.
- The FSM, operand latch and product register stay in mul_share_arbiter.

Test Plan:
- Single request: n_req=4, dp_width=5, req[0]=1 with 10111 x 10011 -> ack[0] one cycle, one mul_start pulse, done[0] after dp_width+4 cycles, product_out=0110110101 (437), busy low the cycle after done.
- Round-robin: req=1111 held continuously, distinct operands -> grants in order 0,1,2,3,0. Each product_out matches its slice (e.g. req2: 11111 x 11111 = 1111000001). Exactly one done bit per completion.
- Priority rotation: grant req[2] (requester 2 just served), then assert req[1] and req[3] together -> req[3] granted first, then req[1].
- Withdrawal and boundaries: req[1] pulsed for one cycle while busy -> no ack[1], no done[1]. Operands 00000 x 11111 -> 0000000000. Operands 11111 x 00001 -> 0000011111.
- Reset mid-operation: assert reset_b=0 during WAIT_DONE -> all outputs 0 asynchronously, no done pulse. After release, req[0] gets a fresh grant from rr_ptr=0.
- Ready gating: hold mul_ready=0 with req[3]=1 in IDLE -> no ack. Raise mul_ready -> ack[3] on the next edge.
